// File: rtl/wb_sel_pipe.sv
// Writeback source select and load-extension stage with a registered output
// and a small FSM that holds the pipe while a multiply/divide result is pending.
module wb_sel_pipe #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RD_W      = 5,
    parameter int unsigned PC_OFFSET = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] in_alu,
    input  logic [WIDTH-1:0] in_mem,
    input  logic [1:0]       in_addr_lo,
    input  logic [2:0]       in_ld_type,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [15:0]      in_imm,
    input  logic [RD_W-1:0]  in_rd,
    input  logic [WIDTH-1:0] mdu_result,
    input  logic             mdu_done,
    input  logic             stall,
    input  logic             flush,
    output logic             wb_we,
    output logic [RD_W-1:0]  wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             stall_req
);

    typedef enum logic {
        IDLE,
        WAIT_MDU
    } state_t;

    state_t            state, state_nx;
    logic [RD_W-1:0]   rd_lat, rd_lat_nx;
    logic              we_nx;
    logic [RD_W-1:0]   rd_nx;
    logic [WIDTH-1:0]  data_nx;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [WIDTH-1:0]  mem_data;
    logic [WIDTH-1:0]  src_data;
    logic              mdu_req;

    always_comb begin
        ld_byte = in_mem[{in_addr_lo, 3'b000} +: 8];
        ld_half = in_mem[{in_addr_lo[1], 4'b0000} +: 16];
        case (in_ld_type)
            3'd1:    mem_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            3'd2:    mem_data = WIDTH'(ld_byte);
            3'd3:    mem_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
            3'd4:    mem_data = WIDTH'(ld_half);
            default: mem_data = in_mem;
        endcase
    end

    // Reserved selects fall to zero data so the write path needs no extra mux.
    always_comb begin
        case (in_sel)
            3'd0:    src_data = in_alu;
            3'd1:    src_data = mem_data;
            3'd2:    src_data = in_pc + WIDTH'(PC_OFFSET);
            3'd3:    src_data = WIDTH'({in_imm, 16'h0000});
            3'd4:    src_data = mdu_result;
            default: src_data = '0;
        endcase
    end

    assign mdu_req   = in_valid && (in_sel == 3'd4) && !mdu_done;
    assign stall_req = ((state == IDLE) && mdu_req) ||
                       ((state == WAIT_MDU) && !mdu_done);

    always_comb begin
        state_nx  = state;
        rd_lat_nx = rd_lat;
        we_nx     = 1'b0;
        rd_nx     = wb_rd;
        data_nx   = wb_data;
        case (state)
            IDLE: begin
                if (mdu_req) begin
                    state_nx  = WAIT_MDU;
                    rd_lat_nx = in_rd;
                end else if (in_valid) begin
                    rd_nx   = in_rd;
                    data_nx = src_data;
                    we_nx   = (in_sel <= 3'd4) && (in_rd != '0);
                end
            end
            WAIT_MDU: begin
                if (mdu_done) begin
                    state_nx = IDLE;
                    rd_nx    = rd_lat;
                    data_nx  = mdu_result;
                    we_nx    = (rd_lat != '0);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rd_lat  <= '0;
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (flush) begin
            state <= IDLE;
            wb_we <= 1'b0;
        end else if (!stall) begin
            state   <= state_nx;
            rd_lat  <= rd_lat_nx;
            wb_we   <= we_nx;
            wb_rd   <= rd_nx;
            wb_data <= data_nx;
        end
    end

endmodule

// File: doc/wb_sel_pipe.md
WB_SEL_PIPE -- requirements
Module: wb_sel_pipe

Interface
REQ-001 The module SHALL have these parameters, one per line: name, default, meaning.
- WIDTH, 32, datapath width; legal values >= 32.
- RD_W, 5, register-index width.
- PC_OFFSET, 8, link-address offset added to in_pc.
REQ-002 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  writeback request present this cycle.
- in_sel  input  3  source select: 0 ALU, 1 MEM, 2 LINK, 3 LUI, 4 MDU, 5-7 reserved.
- in_alu  input  WIDTH  ALU result.
- in_mem  input  WIDTH  raw memory word.
- in_addr_lo  input  2  byte offset of the load address.
- in_ld_type  input  3  load type: 0 word, 1 byte signed, 2 byte unsigned, 3 half signed, 4 half unsigned, 5-7 treated as word.
- in_pc  input  WIDTH  instruction address.
- in_imm  input  16  instruction immediate.
- in_rd  input  RD_W  destination register.
- mdu_result  input  WIDTH  multiply/divide unit result.
- mdu_done  input  1  mdu_result is valid this cycle.
- stall  input  1  downstream hold.
- flush  input  1  discard the pending request.
- wb_we  output  1  registered write enable.
- wb_rd  output  RD_W  registered destination.
- wb_data  output  WIDTH  registered write data.
- stall_req  output  1  upstream stall request while waiting on the MDU.

Function
REQ-003 Source data SHALL be selected as follows:
- ALU: in_alu.
- LINK: in_pc + PC_OFFSET, modulo 2^WIDTH.
- LUI: {in_imm, 16'b0}, zero-extended to WIDTH.
- MDU: mdu_result.
REQ-004 MEM source data SHALL be extracted from in_mem as follows:
- byte: bits [8*in_addr_lo+7 : 8*in_addr_lo].
- half: bits [16*in_addr_lo[1]+15 : 16*in_addr_lo[1]]; in_addr_lo[0] is ignored.
- result: extended to WIDTH, sign or zero per in_ld_type.
REQ-005 A reserved in_sel SHALL produce wb_we=0 and wb_data=0.
REQ-006 An accepted request SHALL update wb_we, wb_rd and wb_data exactly one cycle after acceptance.
REQ-007 wb_we SHALL be 0 whenever the captured in_rd == 0, regardless of source.
REQ-008 The FSM SHALL have states IDLE and WAIT_MDU; the reset state is IDLE.
REQ-009 IDLE transitions SHALL be:
- in_valid=1, in_sel=4, mdu_done=0, no stall/flush: go to WAIT_MDU; latch in_rd; output regs take wb_we=0.
- any other in_valid=1, no stall/flush: request accepted this cycle (latency per REQ-006).
- in_valid=0: wb_we=0 next cycle.
REQ-010 In WAIT_MDU, in_* inputs SHALL be ignored; the latched rd is used.
REQ-011 In WAIT_MDU with mdu_done=1, the module SHALL capture mdu_result with the latched rd next cycle and return to IDLE.
REQ-012 stall_req SHALL be combinational and equal 1 exactly in these cases:
- state IDLE, in_valid=1, in_sel=4, mdu_done=0.
- state WAIT_MDU, mdu_done=0.
REQ-013 When stall=1, all registers including the FSM state SHALL hold their values; flush and reset take precedence over stall.
REQ-014 When flush=1, the module SHALL clear wb_we to 0, set the FSM to IDLE, and drop any pending MDU wait; wb_rd and wb_data are don't-care.
REQ-015 Priority SHALL be reset > flush > stall > normal operation.
REQ-016 If mdu_done=1 while the FSM is IDLE and no MDU request is present, the pulse SHALL be ignored.

Reset
REQ-017 On a clock edge with reset=1, the module SHALL set the FSM to IDLE and clear wb_we=0, wb_rd=0, wb_data=0.
REQ-018 stall_req SHALL be 0 in the first cycle after reset when in_valid=0.
REQ-019 A reset asserted during WAIT_MDU SHALL abandon the wait; no write is produced for it.

Verification
REQ-020 The bench SHALL cover ALU, LINK and LUI selects:
- in_sel=0, in_alu=0x12345678, in_rd=3 -> next cycle wb_we=1, wb_rd=3, wb_data=0x12345678.
- in_sel=2, in_pc=0x00003000 -> wb_data=0x00003008.
- in_sel=3, in_imm=0xABCD -> wb_data=0xABCD0000.
REQ-021 The bench SHALL cover load extension with in_mem=0x80FF7F01:
- lb, addr_lo=2 -> 0xFFFFFFFF.
- lbu, addr_lo=3 -> 0x00000080.
- lh, addr_lo=2 -> 0xFFFF80FF.
- lhu, addr_lo=0 -> 0x00007F01.
REQ-022 The bench SHALL cover an MDU wait: in_sel=4, rd=7, mdu_done=0 for 3 cycles then 1 with mdu_result=0xDEADBEEF -> stall_req=1 for exactly 3 cycles; wb_we=0 until the cycle after done, then wb_rd=7, wb_data=0xDEADBEEF.
REQ-023 The bench SHALL cover flush during WAIT_MDU: flush=1 -> next cycle wb_we=0, stall_req=0, FSM IDLE; a later mdu_done pulse produces no write.
REQ-024 The bench SHALL cover rd=0 and a reserved select: in_sel=0 with in_rd=0 -> wb_we=0; in_sel=6 -> wb_we=0, wb_data=0.
REQ-025 The bench SHALL cover stall hold: an accepted ALU write followed by stall=1 for 2 cycles -> outputs unchanged for both cycles; input changes during the stall are ignored.
